branch_resolve: RTL and testbench

- EX-stage branch resolution unit, directly downstream of branch_predictor.
- Evaluates the branch condition of the instruction in ID/EX and compares it with the prediction carried down the pipe.
- Produces branch_result, skip_en and flush, which feed back into branch_predictor, plus the corrected fetch PC.
- Squashes wrong-path branches in the flush shadow and keeps saturating branch/mispredict counters.

---
 rtl/branch_pkg.sv | 14 +
 rtl/branch_cond.sv | 18 +
 rtl/branch_resolve.sv | 70 +++++++
 tb/tb_branch_resolve.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: shared branch-type encodings, resolve FSM states and the default fall-through increment
package branch_pkg;
  localparam int PC_INC_DEFAULT = 1;
  typedef enum logic [1:0] {
    BR_BEQ  = 2'b00,
    BR_BNE  = 2'b01,
    BR_BLTZ = 2'b10,
    BR_BGTZ = 2'b11
  } br_type_t;
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } state_t;
endpackage

// File: rtl/branch_cond.sv
// branch_cond: combinational branch condition (br_type, rs, rt -> taken), signed zero tests on rs
module branch_cond
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            br_type,
  input  logic [DATA_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rt,
  output logic                  taken
);
  logic neg;
  assign neg = rs[DATA_WIDTH-1];
  assign taken = br_type == BR_BEQ  ? rs == rt :
                 br_type == BR_BNE  ? rs != rt :
                 br_type == BR_BLTZ ? neg :
                 !neg && |rs;
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch resolution with mispredict flush/redirect, wrong-path shadow squash and saturating counters
module branch_resolve
  import branch_pkg::*;
#(
  parameter int PC_WIDTH      = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int PC_INC        = PC_INC_DEFAULT,
  parameter int SHADOW_CYCLES = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch_inst_idex,
  input  logic                  prediction_idex,
  input  logic [1:0]            br_type_idex,
  input  logic [PC_WIDTH-1:0]   pc_addr_idex,
  input  logic [PC_WIDTH-1:0]   target_addr_idex,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic                  branch_result,
  output logic                  skip_en,
  output logic                  flush,
  output logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [CNT_WIDTH-1:0]  branch_cnt,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt
);
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic taken, active, miss;
  logic [PC_WIDTH-1:0] fallthrough;
  branch_cond #(.DATA_WIDTH(DATA_WIDTH)) u_cond (
    .br_type(br_type_idex),
    .rs     (rs_data),
    .rt     (rt_data),
    .taken  (taken)
  );
  assign fallthrough = pc_addr_idex + PC_WIDTH'(PC_INC);
  assign active = branch_inst_idex && !stall && state == ST_RUN;
  assign miss = active && taken != prediction_idex;
  always_comb begin
    state_nx = stall ? state : miss ? ST_SHADOW : (state == ST_SHADOW && cnt == 3'd1) ? ST_RUN : state;
    cnt_nx = stall ? cnt : miss ? 3'(SHADOW_CYCLES) : state == ST_SHADOW ? cnt - 3'd1 : cnt;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_RUN;
      cnt            <= '0;
      branch_result  <= 1'b0;
      skip_en        <= 1'b0;
      flush          <= 1'b0;
      redirect_pc    <= '0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      skip_en <= active;
      flush   <= miss;
      if (active) begin
        branch_result <= taken;
        if (branch_cnt != '1) branch_cnt <= branch_cnt + 1'b1;
      end
      if (miss) begin
        redirect_pc <= taken ? target_addr_idex : fallthrough;
        if (mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed and random checks of branch_resolve against a shadow-budget reference model
module tb_branch_resolve;
  localparam int SHADOW = 2;
  localparam int CMAX = 65535;
  logic clk = 1'b0, reset = 1'b0, stall = 1'b0;
  logic branch_inst_idex = 1'b0, prediction_idex = 1'b0;
  logic [1:0] br_type_idex = 2'b00;
  logic [31:0] pc_addr_idex = '0, target_addr_idex = '0, rs_data = '0, rt_data = '0;
  logic branch_result, skip_en, flush;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt, mispredict_cnt;
  int n_checks = 0, n_fail = 0;
  logic m_res = 0, m_skip = 0, m_flush = 0;
  logic [31:0] m_redir = '0;
  int m_bcnt = 0, m_mcnt = 0, shadow_left = 0;
  always #5 clk = ~clk;
  branch_resolve dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .branch_inst_idex(branch_inst_idex),
    .prediction_idex (prediction_idex),
    .br_type_idex    (br_type_idex),
    .pc_addr_idex    (pc_addr_idex),
    .target_addr_idex(target_addr_idex),
    .rs_data         (rs_data),
    .rt_data         (rt_data),
    .branch_result   (branch_result),
    .skip_en         (skip_en),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .branch_cnt      (branch_cnt),
    .mispredict_cnt  (mispredict_cnt)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic cond(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      2'd0: return a == b;
      2'd1: return a != b;
      2'd2: return $signed(a) < 0;
      default: return $signed(a) > 0;
    endcase
  endfunction
  task automatic model_reset();
    m_res = 0; m_skip = 0; m_flush = 0; m_redir = '0;
    m_bcnt = 0; m_mcnt = 0; shadow_left = 0;
  endtask
  task automatic model_step();
    logic t;
    m_skip = 0;
    m_flush = 0;
    if (stall) return;
    if (shadow_left > 0) begin
      shadow_left--;
      return;
    end
    if (!branch_inst_idex) return;
    t = cond(br_type_idex, rs_data, rt_data);
    m_res = t;
    m_skip = 1;
    if (m_bcnt < CMAX) m_bcnt++;
    if (t != prediction_idex) begin
      m_flush = 1;
      m_redir = t ? target_addr_idex : pc_addr_idex + 32'd1;
      if (m_mcnt < CMAX) m_mcnt++;
      shadow_left = SHADOW;
    end
  endtask
  task automatic compare_all();
    check("branch_result", 64'(branch_result), 64'(m_res));
    check("skip_en", 64'(skip_en), 64'(m_skip));
    check("flush", 64'(flush), 64'(m_flush));
    if (m_flush) check("redirect_pc", 64'(redirect_pc), 64'(m_redir));
    check("branch_cnt", 64'(branch_cnt), 64'(m_bcnt));
    check("mispredict_cnt", 64'(mispredict_cnt), 64'(m_mcnt));
    if (flush) check("flush_implies_skip", 64'(skip_en), 64'd1);
  endtask
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask
  task automatic br(input logic [1:0] t, input logic p, input logic [31:0] pc, input logic [31:0] tg,
                    input logic [31:0] a, input logic [31:0] b);
    stall = 0; branch_inst_idex = 1; br_type_idex = t; prediction_idex = p;
    pc_addr_idex = pc; target_addr_idex = tg; rs_data = a; rt_data = b;
    cycle();
  endtask
  task automatic idle();
    stall = 0; branch_inst_idex = 0;
    cycle();
  endtask
  initial begin
    #3;
    check("reset_skip", 64'(skip_en), 64'd0);
    check("reset_flush", 64'(flush), 64'd0);
    check("reset_result", 64'(branch_result), 64'd0);
    check("reset_redirect", 64'(redirect_pc), 64'd0);
    check("reset_bcnt", 64'(branch_cnt), 64'd0);
    check("reset_mcnt", 64'(mispredict_cnt), 64'd0);
    #9 reset = 1;
    br(2'd0, 1, 32'h40, 32'h80, 32'd5, 32'd5);
    check("beq_result", 64'(branch_result), 64'd1);
    check("beq_skip", 64'(skip_en), 64'd1);
    check("beq_flush", 64'(flush), 64'd0);
    check("beq_bcnt", 64'(branch_cnt), 64'd1);
    br(2'd1, 1, 32'h40, 32'h80, 32'd7, 32'd7);
    check("bne_flush", 64'(flush), 64'd1);
    check("bne_redirect", 64'(redirect_pc), 64'h41);
    check("bne_mcnt", 64'(mispredict_cnt), 64'd1);
    br(2'd0, 1, 32'h50, 32'h60, 32'd1, 32'd1);
    check("shadow1_skip", 64'(skip_en), 64'd0);
    check("shadow1_flush", 64'(flush), 64'd0);
    br(2'd0, 1, 32'h51, 32'h60, 32'd1, 32'd1);
    check("shadow2_skip", 64'(skip_en), 64'd0);
    br(2'd0, 1, 32'h52, 32'h60, 32'd1, 32'd1);
    check("post_shadow_skip", 64'(skip_en), 64'd1);
    br(2'd2, 0, 32'h20, 32'h10, 32'hFFFF_FFFF, 32'd0);
    check("bltz_result", 64'(branch_result), 64'd1);
    check("bltz_flush", 64'(flush), 64'd1);
    check("bltz_redirect", 64'(redirect_pc), 64'h10);
    idle();
    idle();
    br(2'd2, 0, 32'h20, 32'h10, 32'd0, 32'd0);
    check("bltz_zero_flush", 64'(flush), 64'd0);
    check("bltz_zero_skip", 64'(skip_en), 64'd1);
    br(2'd3, 1, 32'hFFFF_FFFF, 32'h100, 32'd0, 32'd0);
    check("wrap_flush", 64'(flush), 64'd1);
    check("wrap_redirect", 64'(redirect_pc), 64'h0);
    idle();
    idle();
    br(2'd3, 0, 32'h30, 32'h90, 32'd9, 32'd0);
    check("stall_mis_flush", 64'(flush), 64'd1);
    for (int i = 0; i < 3; i++) begin
      stall = 1;
      branch_inst_idex = 1;
      cycle();
      check("stall_skip", 64'(skip_en), 64'd0);
    end
    br(2'd0, 1, 32'h70, 32'h0, 32'd3, 32'd3);
    check("stall_shadow1", 64'(skip_en), 64'd0);
    br(2'd0, 1, 32'h71, 32'h0, 32'd3, 32'd3);
    check("stall_shadow2", 64'(skip_en), 64'd0);
    br(2'd0, 1, 32'h72, 32'h0, 32'd3, 32'd3);
    check("stall_run", 64'(skip_en), 64'd1);
    br(2'd1, 1, 32'h40, 32'h80, 32'd7, 32'd7);
    check("rst_pre_flush", 64'(flush), 64'd1);
    #2 reset = 0;
    #1;
    model_reset();
    check("rst_async_flush", 64'(flush), 64'd0);
    check("rst_async_bcnt", 64'(branch_cnt), 64'd0);
    check("rst_async_mcnt", 64'(mispredict_cnt), 64'd0);
    @(negedge clk);
    reset = 1;
    br(2'd0, 1, 32'h40, 32'h80, 32'd5, 32'd5);
    check("rst_run_skip", 64'(skip_en), 64'd1);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      stall = $urandom_range(0, 4) == 0;
      branch_inst_idex = $urandom_range(0, 9) < 7;
      br_type_idex = 2'($urandom_range(0, 3));
      prediction_idex = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 3)) - 32'd1;
      b = $urandom_range(0, 1) == 0 ? a : $urandom;
      rs_data = a;
      rt_data = b;
      pc_addr_idex = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFFF : $urandom;
      target_addr_idex = $urandom;
      cycle();
    end
    for (int i = 0; i < 65540; i++) br(2'd0, 1, 32'h8, 32'h9, 32'd0, 32'd0);
    check("sat_bcnt", 64'(branch_cnt), 64'hFFFF);
    br(2'd0, 0, 32'h8, 32'h9, 32'd0, 32'd0);
    check("sat_bcnt_hold", 64'(branch_cnt), 64'hFFFF);
    check("sat_mis_flush", 64'(flush), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
